// File: rtl/request_unit.sv
// rtl/request_unit.sv - memory request sequencer between the cache ports and the decode/control stage
module request_unit #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [ADDR_W-1:0] pc,
  input  logic              ihit,
  input  logic [WORD_W-1:0] imemload,
  output logic              imemREN,
  output logic [ADDR_W-1:0] imemaddr,
  output logic [WORD_W-1:0] instr,
  output logic              instr_valid,
  input  logic              dmem_rd_req,
  input  logic              dmem_wr_req,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [WORD_W-1:0] dmem_wdat,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  output logic              dREN,
  output logic              dWEN,
  output logic [ADDR_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic [WORD_W-1:0] rdat,
  output logic              pc_en,
  input  logic              halt_in,
  output logic              halt,
  output logic [31:0]       retired
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALTED = 3'd5
  } state_t;

  state_t state, next_state;
  logic   op_wr;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      instr     <= '0;
      rdat      <= '0;
      dmemaddr  <= '0;
      dmemstore <= '0;
      retired   <= '0;
      halt      <= 1'b0;
      op_wr     <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        FETCH: if (ihit) instr <= imemload;
        EXEC: begin
          if (halt_in) begin
            halt <= 1'b1;
          end else if (dmem_rd_req || dmem_wr_req) begin
            dmemaddr  <= dmem_addr;
            dmemstore <= dmem_wdat;
            // a request flagged as both read and write is treated as a store
            op_wr     <= dmem_wr_req;
          end else begin
            retired <= retired + 32'd1;
          end
        end
        MEM: if (dhit && !op_wr) rdat <= dmemload;
        WB:  retired <= retired + 32'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state  = state;
    imemREN     = 1'b0;
    imemaddr    = '0;
    instr_valid = 1'b0;
    dREN        = 1'b0;
    dWEN        = 1'b0;
    pc_en       = 1'b0;
    case (state)
      IDLE: next_state = FETCH;
      FETCH: begin
        imemREN  = 1'b1;
        imemaddr = pc;
        if (ihit) next_state = EXEC;
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (halt_in) begin
          next_state = HALTED;
        end else if (dmem_rd_req || dmem_wr_req) begin
          next_state = MEM;
        end else begin
          pc_en      = 1'b1;
          next_state = FETCH;
        end
      end
      MEM: begin
        dREN = !op_wr;
        dWEN = op_wr;
        if (dhit) next_state = WB;
      end
      WB: begin
        instr_valid = 1'b1;
        pc_en       = 1'b1;
        next_state  = FETCH;
      end
      HALTED: next_state = HALTED;
      default: next_state = IDLE;
    endcase
  end

endmodule
